// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected layer MAC sequencer.
// Holds the FSM state encoding, default layer geometry and group-count arithmetic.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_STORE,
      ST_DONE
   } fc_state_t;

   localparam int FC_IN_LEN   = 784;
   localparam int FC_OUT_LEN  = 10;
   localparam int FC_NUM_CORE = 4;

   function automatic int fc_ngroup(input int out_len, input int num_core);
      return (out_len + num_core - 1) / num_core;
   endfunction

   // A 1-deep range still needs a 1-bit port.
   function automatic int fc_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fc_addr_counter.sv
// Wrap-at-limit counter with synchronous clear and enable; term flags the last value.
// Count updates on the edge after en; no backpressure of its own.
module fc_addr_counter #(
   parameter int LIMIT = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         term
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   assign term = (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= term ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/fc_mac_sequencer.sv
// Sequences input/weight reads and MAC valid/store strobes for one FC layer, one core group at a time.
// Latency NGROUP*(IN_LEN+2)+1 cycles start-to-done with hold low; hold stalls read issue only.
module fc_mac_sequencer
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IN_LEN     = FC_IN_LEN,
   parameter int OUT_LEN    = FC_OUT_LEN,
   parameter int NUM_CORE   = FC_NUM_CORE,
   localparam int NGROUP    = fc_ngroup(OUT_LEN, NUM_CORE),
   localparam int IAW       = fc_width(IN_LEN),
   localparam int WAW       = fc_width(NGROUP * IN_LEN),
   localparam int NBW       = fc_width(OUT_LEN + NUM_CORE),
   localparam int GW        = fc_width(NGROUP)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                hold,
   output logic                rd_en,
   output logic [IAW-1:0]      in_addr,
   output logic [WAW-1:0]      w_addr,
   output logic                mac_valid,
   output logic                mac_store,
   output logic [NUM_CORE-1:0] core_en,
   output logic [NBW-1:0]      neuron_base,
   output logic                busy,
   output logic                done
);

   if (DATA_WIDTH < 1 || IN_LEN < 1 || OUT_LEN < 1 || NUM_CORE < 1) begin : g_param_check
      $error("fc_mac_sequencer: all size parameters must be at least 1");
   end

   fc_state_t     state;
   logic [GW-1:0] group;
   logic          in_term;
   logic          group_term;
   logic          start_acc;
   logic          grp_inc;

   assign start_acc = (state == ST_IDLE) && start;
   assign rd_en     = (state == ST_FETCH) && !hold;
   assign grp_inc   = (state == ST_STORE) && !group_term;

   fc_addr_counter #(
      .LIMIT (IN_LEN),
      .W     (IAW)
   ) u_in_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start_acc),
      .en    (rd_en),
      .count (in_addr),
      .term  (in_term)
   );

   // Group never wraps: it holds the last value through DONE and is cleared by the next start.
   fc_addr_counter #(
      .LIMIT (NGROUP),
      .W     (GW)
   ) u_grp_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start_acc),
      .en    (grp_inc),
      .count (group),
      .term  (group_term)
   );

   assign w_addr      = WAW'(group) * WAW'(IN_LEN) + WAW'(in_addr);
   assign neuron_base = NBW'(group) * NBW'(NUM_CORE);

   always_comb begin
      core_en = '0;
      for (int k = 0; k < NUM_CORE; k++) begin
         core_en[k] = ((int'(group) * NUM_CORE + k) < OUT_LEN);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         mac_valid <= 1'b0;
         mac_store <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mac_valid <= rd_en;
         mac_store <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (rd_en && in_term) begin
                  state <= ST_DRAIN;
               end
            end
            // The last read's data arrives here, so the store is scheduled for the next cycle.
            ST_DRAIN: begin
               state     <= ST_STORE;
               mac_store <= 1'b1;
            end
            ST_STORE: begin
               if (group_term) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Directed bench for fc_mac_sequencer at IN_LEN=4, OUT_LEN=6, NUM_CORE=4 (two groups, last one half full).
module tb_fc_mac_sequencer;

   localparam int IN_LEN   = 4;
   localparam int OUT_LEN  = 6;
   localparam int NUM_CORE = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       hold  = 1'b0;
   logic       rd_en, mac_valid, mac_store, busy, done;
   logic [1:0] in_addr;
   logic [2:0] w_addr;
   logic [3:0] core_en;
   logic [3:0] neuron_base;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fc_mac_sequencer #(
      .DATA_WIDTH (8),
      .IN_LEN     (IN_LEN),
      .OUT_LEN    (OUT_LEN),
      .NUM_CORE   (NUM_CORE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .hold        (hold),
      .rd_en       (rd_en),
      .in_addr     (in_addr),
      .w_addr      (w_addr),
      .mac_valid   (mac_valid),
      .mac_store   (mac_store),
      .core_en     (core_en),
      .neuron_base (neuron_base),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Memory and MAC-core model: 1-cycle read latency, accumulate on mac_valid, clear after store.
   int in_mem [IN_LEN] = '{1, 2, 3, 4};
   int w_mem  [8];
   int in_q, w_q;
   int acc [NUM_CORE];
   bit sb_on   = 1'b0;
   int sb_hits = 0;

   always @(posedge clk) begin
      if (rd_en) begin
         in_q <= in_mem[in_addr];
         w_q  <= w_mem[w_addr];
      end
      for (int k = 0; k < NUM_CORE; k++) begin
         if (mac_store)      acc[k] <= 0;
         else if (mac_valid) acc[k] <= acc[k] + in_q * w_q;
      end
   end

   always @(negedge clk) begin
      if (sb_on && mac_store) begin
         for (int k = 0; k < NUM_CORE; k++) begin
            if (core_en[k]) begin
               check($sformatf("core%0d_result_nb%0d", k, neuron_base), acc[k], 20);
               sb_hits++;
            end
         end
      end
   end

   typedef struct {
      logic start;
      logic hold;
      logic rd;
      logic mv;
      logic ms;
      logic bz;
      logic dn;
      logic chk_addr;
      int   ia;
      int   wa;
      int   ce;
      int   nb;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic st, input logic hd, input logic rd, input logic mv,
                               input logic ms, input logic bz, input logic dn, input logic ck,
                               input int ia, input int wa, input int ce, input int nb);
      vec_t v;
      v.start = st; v.hold = hd; v.rd = rd; v.mv = mv; v.ms = ms; v.bz = bz; v.dn = dn;
      v.chk_addr = ck; v.ia = ia; v.wa = wa; v.ce = ce; v.nb = nb;
      return v;
   endfunction

   int addr_q [$];

   // Caller is just after a rising edge with the DUT idle; cycle 0 is the start-accept cycle.
   task automatic run_layer(input int hold_lo, input int hold_hi, input int st_a, input int st_b,
                            input int ncyc, output int first_store, output int done_cyc,
                            output int n_done, output int n_store, output int mv_g0,
                            output int rd_late);
      first_store = -1; done_cyc = -1; n_done = 0; n_store = 0; mv_g0 = 0; rd_late = 0;
      addr_q.delete();
      start = 1'b1;
      hold  = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= ncyc; k++) begin
         start = (k == st_a) || (k == st_b);
         hold  = (k >= hold_lo) && (k <= hold_hi);
         @(negedge clk);
         if (rd_en && n_store == 0)     addr_q.push_back(int'(in_addr));
         if (mac_valid && n_store == 0) mv_g0++;
         if (rd_en && n_done > 0)       rd_late++;
         if (mac_store) begin
            n_store++;
            if (first_store < 0) first_store = k;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = k;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      hold  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs, dc, nd, ns, mv, rl, seen;

      for (int i = 0; i < 8; i++) w_mem[i] = 2;

      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 0);
      tbl[1]  = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 15, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 15, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 2, 15, 0);
      tbl[4]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 3, 3, 15, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 15, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 15, 0);
      tbl[7]  = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 4,  3, 4);
      tbl[8]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 1, 5,  3, 4);
      tbl[9]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 2, 6,  3, 4);
      tbl[10] = mk(0, 0, 1, 1, 0, 1, 0, 1, 3, 7,  3, 4);
      tbl[11] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 4,  3, 4);
      tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 4,  3, 4);
      tbl[13] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0);

      // Reset state
      @(negedge clk);
      check("reset_rd_en", rd_en, 0);
      check("reset_mac_valid", mac_valid, 0);
      check("reset_mac_store", mac_store, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_in_addr", in_addr, 0);
      check("reset_neuron_base", neuron_base, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Nominal layer, cycle by cycle
      for (int i = 0; i < 15; i++) begin
         start = tbl[i].start;
         hold  = tbl[i].hold;
         @(negedge clk);
         check($sformatf("row%0d_rd_en", i), rd_en, tbl[i].rd);
         check($sformatf("row%0d_mac_valid", i), mac_valid, tbl[i].mv);
         check($sformatf("row%0d_mac_store", i), mac_store, tbl[i].ms);
         check($sformatf("row%0d_busy", i), busy, tbl[i].bz);
         check($sformatf("row%0d_done", i), done, tbl[i].dn);
         if (tbl[i].chk_addr) begin
            check($sformatf("row%0d_in_addr", i), in_addr, tbl[i].ia);
            check($sformatf("row%0d_w_addr", i), w_addr, tbl[i].wa);
            check($sformatf("row%0d_core_en", i), core_en, tbl[i].ce);
            check($sformatf("row%0d_neuron_base", i), neuron_base, tbl[i].nb);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;

      // hold for 3 cycles after the second read of group 0
      run_layer(3, 5, -1, -1, 20, fs, dc, nd, ns, mv, rl);
      check("hold_first_store_cycle", fs, 9);
      check("hold_mac_valid_count", mv, 4);
      check("hold_addr_count", addr_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < addr_q.size()) check($sformatf("hold_addr%0d", i), addr_q[i], i);
      end
      check("hold_done_cycle", dc, 16);
      check("hold_store_count", ns, 2);

      // start during FETCH and during DONE is ignored
      run_layer(-1, -1, 2, 13, 25, fs, dc, nd, ns, mv, rl);
      check("ign_done_count", nd, 1);
      check("ign_done_cycle", dc, 13);
      check("ign_first_store", fs, 6);
      check("ign_store_count", ns, 2);
      check("ign_reads_after_done", rl, 0);

      // Reset during group 1 FETCH
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      check("abort_pre_in_addr", in_addr, 1);
      check("abort_pre_w_addr", w_addr, 5);
      reset = 1'b0;
      #1;
      check("abort_rd_en", rd_en, 0);
      check("abort_in_addr", in_addr, 0);
      check("abort_w_addr", w_addr, 0);
      check("abort_mac_valid", mac_valid, 0);
      check("abort_mac_store", mac_store, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_neuron_base", neuron_base, 0);
      @(negedge clk);
      check("abort_edge_mac_store", mac_store, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (mac_store || busy || rd_en || mac_valid || done) seen++;
      end
      @(posedge clk); #1;
      check("abort_quiet_after_release", seen, 0);
      run_layer(-1, -1, -1, -1, 16, fs, dc, nd, ns, mv, rl);
      check("abort_rerun_first_store", fs, 6);
      check("abort_rerun_done_cycle", dc, 13);
      check("abort_rerun_store_count", ns, 2);
      check("abort_rerun_mac_valid", mv, 4);

      // MAC results: inputs 1..4 times weight 2 gives 20 per enabled core
      sb_on   = 1'b1;
      sb_hits = 0;
      run_layer(-1, -1, -1, -1, 16, fs, dc, nd, ns, mv, rl);
      sb_on = 1'b0;
      check("sb_result_count", sb_hits, 6);
      check("sb_done_cycle", dc, 13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
